// File: rtl/qr_frame_loader.sv
// Ping-pong frame capture for the 4x4 complex QR core: replays a captured frame as four row beats.
// Define QR_LOADER_SAT_EN to saturate, rather than truncate, samples narrowed to sfix24_En14.
module qr_frame_loader #(
  parameter int DEPTH     = 512,
  parameter int IMAG_OFS  = 16,
  parameter int ROW_GAP   = 1,
  parameter int FLUSH_CYC = 2
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        index,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic               qr_release,
  input  logic [8:0]         rd_index,
  output logic               clock_en,
  output logic               en_in11,
  output logic [23:0]        A1_r, A1_i, A2_r, A2_i, A3_r, A3_i, A4_r, A4_i,
  output logic [23:0]        B_in_r, B_in_i,
  output logic               frame_start,
  output logic               matrix_done,
  output logic               busy,
  output logic               overflow,
  output logic [31:0]        rd_a,
  output logic [31:0]        rd_b
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 8;

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_GAP, S_FLUSH, S_WAIT} state_t;

  logic [31:0] mem_a [2][DEPTH];
  logic [31:0] mem_b [2][DEPTH];

  state_t         state_q, state_d;
  logic [1:0]     row_q, row_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ce_q, ce_d, en_q, en_d, fs_q, fs_d, md_q, md_d;
  logic [3:0][23:0] ar_q, ar_d, ai_q, ai_d;
  logic [31:0]    last_index_q, rd_a_q, rd_b_q;
  logic           wb_q, pending_q, overflow_q;
  logic [23:0]    bz_q;

  logic           rb, in_rng, wr_req, wr_en, swap;
  logic [AW-1:0]  wr_addr;

  function automatic logic [23:0] narrow(input logic [31:0] x);
`ifdef QR_LOADER_SAT_EN
    if ($signed(x) > 32'sd8388607)       return 24'h7FFFFF;
    else if ($signed(x) < -32'sd8388608) return 24'h800000;
    else                                 return x[23:0];
`else
    return x[23:0];
`endif
  endfunction

  function automatic logic [AW-1:0] raddr(input logic [1:0] r, input int k);
    return AW'(int'(r) * 4 + k);
  endfunction

  assign rb      = ~wb_q;
  assign in_rng  = (index != 32'd0) && (index <= 32'(DEPTH));
  assign wr_req  = (index != last_index_q) && in_rng;
  assign wr_en   = wr_req && !pending_q;
  assign wr_addr = AW'(index - 32'd1);
  // A frame completed while the reader is busy waits here until the reader returns to IDLE.
  assign swap    = pending_q && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_a[wb_q][wr_addr] <= a;
      mem_b[wb_q][wr_addr] <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_index_q <= '0;
      wb_q         <= 1'b0;
      pending_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      last_index_q <= index;
      if (wr_req && pending_q) overflow_q <= 1'b1;
      if (swap) begin
        wb_q      <= ~wb_q;
        pending_q <= 1'b0;
      end else if (wr_en && index == 32'(DEPTH)) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    ce_d    = ce_q;
    en_d    = 1'b0;
    fs_d    = 1'b0;
    md_d    = 1'b0;
    ar_d    = ar_q;
    ai_d    = ai_q;
    case (state_q)
      S_IDLE: begin
        ce_d = 1'b0;
        if (swap) begin
          fs_d    = 1'b1;
          row_d   = 2'd0;
          state_d = S_ROW;
        end
      end
      S_ROW: begin
        ce_d  = 1'b1;
        en_d  = 1'b1;
        cnt_d = '0;
        for (int k = 0; k < 4; k++) begin
          ar_d[k] = narrow(mem_a[rb][raddr(row_q, k)]);
          ai_d[k] = narrow(mem_a[rb][raddr(row_q, k + IMAG_OFS)]);
        end
        if (ROW_GAP > 0)        state_d = S_GAP;
        else if (row_q == 2'd3) state_d = S_FLUSH;
        else                    row_d   = row_q + 2'd1;
      end
      S_GAP: begin
        ce_d = 1'b1;
        if (cnt_q == CW'(ROW_GAP - 1)) begin
          cnt_d = '0;
          if (row_q == 2'd3) state_d = S_FLUSH;
          else begin
            row_d   = row_q + 2'd1;
            state_d = S_ROW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLUSH: begin
        ce_d = 1'b1;
        ar_d = '0;
        ai_d = '0;
        if (cnt_q == CW'(FLUSH_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        ce_d = 1'b1;
        // cnt_q==0 marks the first WAIT cycle, which carries the done pulse.
        if (cnt_q == '0) begin
          md_d  = 1'b1;
          cnt_d = CW'(1);
        end
        if (qr_release) begin
          ce_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      md_q    <= 1'b0;
      ar_q    <= '0;
      ai_q    <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      bz_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
      md_q    <= md_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      rd_a_q  <= (32'(rd_index) < 32'(DEPTH)) ? mem_a[rb][rd_index[AW-1:0]] : '0;
      rd_b_q  <= (32'(rd_index) < 32'(DEPTH)) ? mem_b[rb][rd_index[AW-1:0]] : '0;
      bz_q    <= '0;
    end
  end

  assign clock_en    = ce_q;
  assign en_in11     = en_q;
  assign frame_start = fs_q;
  assign matrix_done = md_q;
  assign busy        = (state_q != S_IDLE);
  assign overflow    = overflow_q;
  assign rd_a        = rd_a_q;
  assign rd_b        = rd_b_q;
  assign B_in_r      = bz_q;
  assign B_in_i      = bz_q;
  assign A1_r = ar_q[0];  assign A1_i = ai_q[0];
  assign A2_r = ar_q[1];  assign A2_i = ai_q[1];
  assign A3_r = ar_q[2];  assign A3_i = ai_q[2];
  assign A4_r = ar_q[3];  assign A4_i = ai_q[3];
endmodule

// File: tb/tb_qr_frame_loader.sv
// Randomized bench for qr_frame_loader against a cycle-timeline model of frame capture and replay.
`timescale 1ns/1ps
module tb_qr_frame_loader;
  localparam int DEPTH = 512, IMAG_OFS = 16, ROW_GAP = 1, FLUSH_CYC = 2;
  localparam int BEAT   = 1 + ROW_GAP;
  localparam int K_WAIT = 4 * BEAT + FLUSH_CYC + 1;

  logic clk = 1'b0, rst = 1'b0, qr_release = 1'b0;
  logic [31:0] index = '0, a = '0, b = '0;
  logic [8:0]  rd_index = '0;
  logic clock_en, en_in11, frame_start, matrix_done, busy, overflow;
  logic [23:0] A1_r, A1_i, A2_r, A2_i, A3_r, A3_i, A4_r, A4_i, B_in_r, B_in_i;
  logic [31:0] rd_a, rd_b;
  logic [23:0] d_ar [4], d_ai [4];

  always #5 clk = ~clk;

  qr_frame_loader dut (
    .clk(clk), .rst(rst), .index(index), .a(a), .b(b), .qr_release(qr_release),
    .rd_index(rd_index), .clock_en(clock_en), .en_in11(en_in11),
    .A1_r(A1_r), .A1_i(A1_i), .A2_r(A2_r), .A2_i(A2_i),
    .A3_r(A3_r), .A3_i(A3_i), .A4_r(A4_r), .A4_i(A4_i),
    .B_in_r(B_in_r), .B_in_i(B_in_i), .frame_start(frame_start),
    .matrix_done(matrix_done), .busy(busy), .overflow(overflow),
    .rd_a(rd_a), .rd_b(rd_b)
  );

  assign d_ar[0] = A1_r; assign d_ar[1] = A2_r; assign d_ar[2] = A3_r; assign d_ar[3] = A4_r;
  assign d_ai[0] = A1_i; assign d_ai[1] = A2_i; assign d_ai[2] = A3_i; assign d_ai[3] = A4_i;

  int n_cmp = 0, n_bad = 0;

  // Model state: two banks with written flags, bank bookkeeping, and cycles since the last swap.
  logic [31:0] m_a [2][DEPTH];
  logic [31:0] m_b [2][DEPTH];
  bit          m_v [2][DEPTH];
  logic [31:0] m_last;
  int  m_wb, m_k;
  bit  m_pend, m_ovf, m_idle = 1'b1;
  bit  e_ce, e_en, e_fs, e_md, e_rdv;
  logic [23:0] e_ar [4], e_ai [4];
  logic [31:0] e_rda, e_rdb;

  function automatic logic [23:0] nar(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
`ifdef QR_LOADER_SAT_EN
    if (v > 8388607)  v = 8388607;
    if (v < -8388608) v = -8388608;
`endif
    return v[23:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int rb_pre, r;
    bit swap, req;
    if (!rst) begin
      m_wb = 0; m_pend = 0; m_last = '0; m_ovf = 0; m_idle = 1; m_k = 0;
      e_ce = 0; e_en = 0; e_fs = 0; e_md = 0;
      for (int j = 0; j < 4; j++) begin e_ar[j] = '0; e_ai[j] = '0; end
      e_rda = '0; e_rdb = '0; e_rdv = 1;
      return;
    end
    rb_pre = 1 - m_wb;
    e_rdv  = m_v[rb_pre][rd_index];
    e_rda  = m_a[rb_pre][rd_index];
    e_rdb  = m_b[rb_pre][rd_index];
    swap   = m_pend && m_idle;
    req    = (index != m_last) && (index >= 1) && (index <= DEPTH);
    if (req) begin
      if (m_pend) m_ovf = 1;
      else begin
        m_a[m_wb][index-1] = a;
        m_b[m_wb][index-1] = b;
        m_v[m_wb][index-1] = 1;
        if (index == DEPTH) m_pend = 1;
      end
    end
    m_last = index;
    e_fs = 0; e_md = 0; e_en = 0;
    if (swap) begin
      m_wb = 1 - m_wb; m_pend = 0; e_fs = 1; m_idle = 0; m_k = 0; e_ce = 0;
    end else if (!m_idle) begin
      m_k++;
      if (m_k <= 4 * BEAT && (m_k - 1) % BEAT == 0) begin
        r = (m_k - 1) / BEAT;
        e_en = 1; e_ce = 1;
        for (int j = 0; j < 4; j++) begin
          e_ar[j] = nar(m_a[1-m_wb][4*r+j]);
          e_ai[j] = nar(m_a[1-m_wb][4*r+j+IMAG_OFS]);
        end
      end else if (m_k < K_WAIT) begin
        e_ce = 1;
        if (m_k > 4 * BEAT)
          for (int j = 0; j < 4; j++) begin e_ar[j] = '0; e_ai[j] = '0; end
      end else begin
        e_md = (m_k == K_WAIT);
        if (qr_release) begin e_ce = 0; m_idle = 1; end
        else e_ce = 1;
      end
    end else begin
      e_ce = 0;
    end
  endtask

  task automatic compare();
    chk("clock_en", clock_en, e_ce);
    chk("en_in11", en_in11, e_en);
    chk("frame_start", frame_start, e_fs);
    chk("matrix_done", matrix_done, e_md);
    chk("busy", busy, !m_idle);
    chk("overflow", overflow, m_ovf);
    chk("B_in_r", B_in_r, 0);
    chk("B_in_i", B_in_i, 0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("A%0d_r", j+1), d_ar[j], e_ar[j]);
      chk($sformatf("A%0d_i", j+1), d_ai[j], e_ai[j]);
    end
    if (e_rdv) begin
      chk("rd_a", rd_a, e_rda);
      chk("rd_b", rd_b, e_rdb);
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] idx, input logic [31:0] av,
                     input logic [31:0] bv, input logic rel, input logic [8:0] rdi);
    rst = r; index = idx; a = av; b = bv; qr_release = rel; rd_index = rdi;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  initial begin
    int en_cnt, guard;
    logic [31:0] f2_a6, f2_b6, av;

    // Reset
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("rst_clock_en", clock_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_A1_r", A1_r, 0);
    chk("rst_rd_a", rd_a, 0);

    // Frame 1: a = k<<14 at index k+1
    for (int k = 0; k < DEPTH; k++)
      cyc(1, 32'(k + 1), 32'(k << 14), $urandom, 0, 9'($urandom_range(0, 511)));
    cyc(1, 512, $urandom, $urandom, 0, 9'($urandom_range(0, 511)));
    chk("fs_latency", frame_start, 1);
    cyc(1, 512, $urandom, $urandom, 0, 9'($urandom_range(0, 511)));
    en_cnt = int'(en_in11);
    chk("row0_en", en_in11, 1);
    chk("row0_A1_r", A1_r, 0);
    chk("row0_A1_i", A1_i, 32'(16 << 14));
    chk("row0_A4_r", A4_r, 32'(3 << 14));
    chk("row0_A4_i", A4_i, 32'(19 << 14));
    for (int i = 0; i < 19; i++) begin
      cyc(1, 512, $urandom, $urandom, 0, 9'($urandom_range(0, 511)));
      en_cnt += int'(en_in11);
      if (i == 1) chk("row1_en", en_in11, 1);
      if (i == 5) chk("row3_A1_r", A1_r, 32'(12 << 14));
    end
    chk("en_pulse_count", en_cnt, 4);

    // Frame 2 loaded while frame 1 is parked in WAIT
    for (int k = 1; k <= DEPTH; k++) begin
      av = (k == 1) ? 32'h0100_0000 : (k == 2) ? 32'(-5 <<< 14) : $urandom;
      if (k == 6) begin f2_a6 = av; f2_b6 = 32'h6666_0000 ^ $urandom_range(0, 255); end
      cyc(1, 32'(k), av, (k == 6) ? f2_b6 : $urandom, 0, 9'($urandom_range(0, 511)));
    end
    cyc(1, 512, $urandom, $urandom, 0, 0);
    chk("pend_no_fs", frame_start, 0);
    chk("pend_busy", busy, 1);
    cyc(1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    chk("overflow_set", overflow, 1);
    cyc(1, 1, 0, 0, 1, 0);
    chk("release_ce_low", clock_en, 0);
    cyc(1, 1, 0, 0, 0, 5);
    chk("fs_after_release", frame_start, 1);
    cyc(1, 1, 0, 0, 0, 5);
    chk("readback_a", rd_a, f2_a6);
    chk("readback_b", rd_b, f2_b6);
`ifdef QR_LOADER_SAT_EN
    chk("narrow_big", A1_r, 32'h7F_FFFF);
`else
    chk("narrow_big", A1_r, 32'h00_0000);
`endif
    chk("narrow_neg", A2_r, 32'hFE_C000);

    // Random traffic: index jumps (incl. out-of-range), random data and releases
    for (int i = 0; i < 600; i++)
      cyc(1, ($urandom_range(0, 3) == 0) ? index : 32'($urandom_range(0, DEPTH + 20)),
          $urandom, $urandom, ($urandom_range(0, 7) == 0), 9'($urandom_range(0, 511)));

    guard = 0;
    while ((!m_idle || m_pend) && guard < 200) begin
      cyc(1, index, $urandom, $urandom, 1, 9'($urandom_range(0, 511)));
      guard++;
    end
    chk("drain_bound", guard < 200, 1);

    // Reset during row 2
    for (int k = 1; k <= DEPTH; k++)
      cyc(1, 32'(k), $urandom, $urandom, 0, 9'($urandom_range(0, 511)));
    guard = 0;
    while (!(m_k == 5 && !m_idle) && guard < 30) begin
      cyc(1, 512, $urandom, $urandom, 0, 9'($urandom_range(0, 511)));
      guard++;
    end
    chk("row2_reached", en_in11, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("midrst_en", en_in11, 0);
    chk("midrst_ce", clock_en, 0);
    en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 0, $urandom, $urandom, $urandom_range(0, 1), 9'($urandom_range(0, 511)));
      en_cnt += int'(en_in11);
    end
    chk("no_en_after_rst", en_cnt, 0);
    chk("idle_after_rst", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
